// File: rtl/int_relu6_backward_pkg.sv
// int_relu6_backward_pkg: shared ReLU6 cap and derivative-mask helpers
package int_relu6_backward_pkg;
  function automatic longint relu6_cap(input int act_bias);
    return longint'(6) << act_bias;
  endfunction
  function automatic logic relu6_grad_mask(input longint act, input longint cap);
    return (act > 0) && (act < cap);
  endfunction
endpackage

// File: rtl/int_relu6_backward_register_slice.sv
// register_slice: single-entry full-throughput output register with valid/ready
module register_slice #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);
  assign in_ready = !out_valid || out_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end
endmodule

// File: rtl/int_relu6_backward.sv
// int_relu6_backward: joins queued forward activations with gradients and masks by the ReLU6 derivative
module int_relu6_backward
  import int_relu6_backward_pkg::*;
#(
  parameter int NUM        = 1,
  parameter int ACT_WIDTH  = 8,
  parameter int ACT_BIAS   = 4,
  parameter int GRAD_WIDTH = 8,
  parameter int ACT_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM*ACT_WIDTH-1:0]      act,
  input  logic                          act_valid,
  output logic                          act_ready,
  input  logic [NUM*GRAD_WIDTH-1:0]     grad,
  input  logic                          grad_valid,
  output logic                          grad_ready,
  output logic [NUM*GRAD_WIDTH-1:0]     out,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(ACT_DEPTH):0]    act_count
);
  localparam int AW = $clog2(ACT_DEPTH);
  localparam longint CAP = relu6_cap(ACT_BIAS);
  localparam logic [AW:0] FULL = (AW+1)'(ACT_DEPTH);
  logic [NUM*ACT_WIDTH-1:0]  mem [ACT_DEPTH];
  logic [AW-1:0]             wr_ptr, rd_ptr;
  logic [NUM*ACT_WIDTH-1:0]  head;
  logic [NUM*GRAD_WIDTH-1:0] masked;
  logic                      slice_ready, push, pop;
  assign act_ready  = (act_count != FULL) && !rst;
  assign grad_ready = (act_count != '0) && slice_ready && !rst;
  assign push = act_valid && act_ready;
  assign pop  = grad_valid && grad_ready;
  assign head = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= act;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      act_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      act_count <= (push && !pop) ? act_count + 1'b1 : (pop && !push) ? act_count - 1'b1 : act_count;
    end
  end
  for (genvar i = 0; i < NUM; i++) begin : g_mask
    assign masked[i*GRAD_WIDTH +: GRAD_WIDTH] =
      relu6_grad_mask(longint'($signed(head[i*ACT_WIDTH +: ACT_WIDTH])), CAP) ? grad[i*GRAD_WIDTH +: GRAD_WIDTH] : '0;
  end
  register_slice #(.DATA_WIDTH(NUM*GRAD_WIDTH)) u_slice (
    .clk       (clk),
    .rst       (rst),
    .in_data   (masked),
    .in_valid  (pop),
    .in_ready  (slice_ready),
    .out_data  (out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );
endmodule
